// File: rtl/mem_access_pkg.sv
// Shared definitions for the byte-serial data memory initiator.
// The access-mode encodings match the data memory's own decode.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } seq_state_t;

  localparam logic ADDR_MODE_BYTE = 1'b1;
  localparam logic ADDR_MODE_WORD = 1'b0;
  localparam int   BYTES_PER_WORD = 4;

  // True when the byte counter has reached the final byte of the access.
  function automatic logic is_last_byte(input logic mode, input logic [1:0] cnt);
    if (mode == ADDR_MODE_BYTE) begin
      return cnt == 2'd0;
    end
    return cnt == 2'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_assembler.sv
// Load data assembly register: one 8-bit lane per byte of the word,
// lane selected by the sequencer's byte counter.
module byte_lane_assembler
  import mem_access_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [1:0]                  lane,
  input  logic [7:0]                  byte_in,
  output logic [BYTES_PER_WORD*8-1:0] data
);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [7:0] byte_reg;

      // Clear on a new request, otherwise capture the byte when this lane is addressed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          byte_reg <= '0;
        end else if (clear) begin
          byte_reg <= '0;
        end else if (wr_en && (lane == 2'(gi))) begin
          byte_reg <= byte_in;
        end
      end

      assign data[gi*8 +: 8] = byte_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_access_sequencer.sv
// Serialises one load/store request into little-endian byte accesses on an
// 8-bit memory port and returns the assembled word as a one-cycle response.
module mem_access_sequencer
  import mem_access_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic                     req_addr_mode,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wd,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rd,
  output logic                     busy,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0]               mem_wd,
  input  logic [7:0]               mem_rd
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_DONE   = DONE;

  logic [1:0]               state_reg, state_next;
  logic [1:0]               cnt_reg, cnt_next;
  logic                     we_reg, we_next;
  logic                     mode_reg, mode_next;
  logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]    wd_reg, wd_next;

  logic                     asm_clear;
  logic                     asm_wr;
  logic [DATA_WIDTH-1:0]    asm_data;

  // Next-state logic: capture in IDLE, walk the byte counter in ACCESS, one DONE cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    mode_next  = mode_reg;
    addr_next  = addr_reg;
    wd_next    = wd_reg;
    asm_clear  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          we_next    = req_we;
          mode_next  = req_addr_mode;
          addr_next  = req_addr;
          wd_next    = req_wd;
          cnt_next   = 2'd0;
          asm_clear  = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (is_last_byte(mode_reg, cnt_reg)) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and captured request registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      mode_reg  <= 1'b0;
      addr_reg  <= '0;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      mode_reg  <= mode_next;
      addr_reg  <= addr_next;
      wd_reg    <= wd_next;
    end
  end

  assign asm_wr = (state_reg == ST_ACCESS) && !we_reg;

  byte_lane_assembler u_assembler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (asm_clear),
    .wr_en   (asm_wr),
    .lane    (cnt_reg),
    .byte_in (mem_rd),
    .data    (asm_data)
  );

  // Output decode: memory port only active in ACCESS, response only in DONE.
  always_comb begin
    req_ready  = (state_reg == ST_IDLE);
    busy       = (state_reg != ST_IDLE) || req_valid;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wd     = 8'h00;
    resp_valid = 1'b0;
    resp_rd    = '0;
    if (state_reg == ST_ACCESS) begin
      mem_addr = addr_reg + ADDRESS_WIDTH'(cnt_reg);
      if (we_reg) begin
        mem_we = 1'b1;
        mem_wd = wd_reg[{cnt_reg, 3'b000} +: 8];
      end
    end
    if (state_reg == ST_DONE) begin
      resp_valid = 1'b1;
      if (!we_reg) begin
        resp_rd = (mode_reg == ADDR_MODE_BYTE) ? DATA_WIDTH'(asm_data[7:0]) : asm_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer. The bench memory is 256 bytes
// indexed by the low 8 address bits, so e.g. 0x00000000 aliases 0x00010000.
module tb_mem_access_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_addr_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wd;
  logic        resp_valid;
  logic [31:0] resp_rd;
  logic        busy;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd;

  logic [7:0]  mem_arr [256];
  logic [7:0]  ref_mem [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [7:0]  pre_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  mem_access_sequencer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr_mode (req_addr_mode),
    .req_addr      (req_addr),
    .req_wd        (req_wd),
    .resp_valid    (resp_valid),
    .resp_rd       (resp_rd),
    .busy          (busy),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wd        (mem_wd),
    .mem_rd        (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide memory: combinational read, write on the clock edge.
  assign mem_rd = mem_arr[mem_addr[7:0]];
  always @(posedge clk) begin
    if (pre_we) mem_arr[pre_addr] <= pre_data;
    else if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wd;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Reference model: what a load returns / a store leaves in memory.
  function automatic logic [31:0] model_load(input logic mode, input logic [31:0] addr);
    logic [31:0] r = 32'h0;
    int n = mode ? 1 : 4;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a = addr + 32'(i);
      r = r | (32'(ref_mem[a[7:0]]) << (8 * i));
    end
    return r;
  endfunction

  task automatic model_store(input logic mode, input logic [31:0] addr, input logic [31:0] wd);
    int n = mode ? 1 : 4;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a = addr + 32'(i);
      ref_mem[a[7:0]] = 8'((wd >> (8 * i)) & 32'hFF);
    end
  endtask

  // Runs one request starting at a negedge with the DUT idle; checks every cycle.
  task automatic run_req(input logic we, input logic mode, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd);
    int n = mode ? 1 : 4;
    req_valid = 1'b1; req_we = we; req_addr_mode = mode; req_addr = addr; req_wd = wd;
    #1;
    check("accept_ready", 32'(req_ready), 32'd1);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_mem_we", 32'(mem_we), 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("acc_addr", mem_addr, addr + 32'(i));
      check("acc_we", 32'(mem_we), 32'(we));
      check("acc_wd", 32'(mem_wd), we ? ((wd >> (8 * i)) & 32'hFF) : 32'h0);
      check("acc_busy", 32'(busy), 32'd1);
      check("acc_ready", 32'(req_ready), 32'd0);
      check("acc_resp_valid", 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    check("done_resp_valid", 32'(resp_valid), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_mem_we", 32'(mem_we), 32'd0);
    rd = resp_rd;
    @(negedge clk);
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic txn(input logic we, input logic mode, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    logic [31:0] rd;
    run_req(we, mode, addr, wd, rd);
    if (we) model_store(mode, addr, wd);
    check(we ? "store_resp_rd" : "load_resp_rd", rd, exp_rd);
    $display("txn %s %s addr=%h wd=%h rd=%h exp=%h", we ? "store" : "load ",
             mode ? "byte" : "word", addr, wd, rd, exp_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr_mode = 1'b0;
    req_addr = 32'h0; req_wd = 32'h0; pre_we = 1'b0; pre_addr = 8'h0; pre_data = 8'h0;
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    for (int a = 0; a < 256; a++) preload(8'(a), 8'h00);
    preload(8'h00, 8'h12); preload(8'h01, 8'h34); preload(8'h02, 8'h56); preload(8'h03, 8'h78);
    preload(8'hFE, 8'hAA); preload(8'hFF, 8'hBB);

    // Reset state
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rd", resp_rd, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wd", 32'(mem_wd), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors from the test plan
    vecs[0] = '{we: 1'b0, mode: 1'b0, addr: 32'h0001_0000, wd: 32'h0,          exp_rd: 32'h7856_3412};
    vecs[1] = '{we: 1'b0, mode: 1'b1, addr: 32'h0001_0002, wd: 32'h0,          exp_rd: 32'h0000_0056};
    vecs[2] = '{we: 1'b1, mode: 1'b0, addr: 32'h0001_0010, wd: 32'hDEAD_BEEF, exp_rd: 32'h0};
    vecs[3] = '{we: 1'b0, mode: 1'b0, addr: 32'h0001_0010, wd: 32'h0,          exp_rd: 32'hDEAD_BEEF};
    vecs[4] = '{we: 1'b0, mode: 1'b0, addr: 32'hFFFF_FFFE, wd: 32'h0,          exp_rd: 32'h3412_BBAA};
    vecs[5] = '{we: 1'b1, mode: 1'b1, addr: 32'h0001_0003, wd: 32'hFFFF_FF9A, exp_rd: 32'h0};
    vecs[6] = '{we: 1'b0, mode: 1'b0, addr: 32'h0001_0000, wd: 32'h0,          exp_rd: 32'h9A56_3412};
    for (int v = 0; v < 7; v++) begin
      txn(vecs[v].we, vecs[v].mode, vecs[v].addr, vecs[v].wd, vecs[v].exp_rd);
    end

    // req_valid held high: accepts only from IDLE, every 6 cycles for words;
    // the address changes outside accept cycles must not leak onto the port.
    for (int c = 0; c < 18; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr_mode = 1'b0;
      req_addr = ((c % 6) == 0) ? 32'h0001_0000 : $urandom;
      #1;
      check("hold_ready", 32'(req_ready), ((c % 6) == 0) ? 32'd1 : 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_mem_addr", mem_addr,
            ((c % 6) >= 1 && (c % 6) <= 4) ? 32'h0001_0000 + 32'((c % 6) - 1) : 32'h0);
      check("hold_mem_we", 32'(mem_we), 32'd0);
      check("hold_resp_valid", 32'(resp_valid), ((c % 6) == 5) ? 32'd1 : 32'd0);
      if ((c % 6) == 5) check("hold_resp_rd", resp_rd, model_load(1'b0, 32'h0001_0000));
      $display("hold cycle %0d ready=%0b mem_addr=%h resp_valid=%0b", c, req_ready, mem_addr, resp_valid);
      @(negedge clk);
    end
    req_valid = 1'b0;
    #1;
    check("hold_end_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Reset abort in the middle of a word store
    preload(8'h20, 8'h01); preload(8'h21, 8'h02); preload(8'h22, 8'h03); preload(8'h23, 8'h04);
    req_valid = 1'b1; req_we = 1'b1; req_addr_mode = 1'b0;
    req_addr = 32'h0001_0020; req_wd = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("abort_pre_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("post_abort_resp_valid", 32'(resp_valid), 32'd0);
      check("post_abort_ready", 32'(req_ready), 32'd1);
      check("post_abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    ref_mem[8'h20] = 8'h44; ref_mem[8'h21] = 8'h33;
    for (int a = 8'h20; a <= 8'h23; a++) check("abort_mem_byte", 32'(mem_arr[a]), 32'(ref_mem[a]));
    $display("abort: reset after 2 bytes of store at 00010020");
    txn(1'b0, 1'b0, 32'h0001_0020, 32'h0, 32'h0403_3344);

    // Randomized traffic checked against the reference model
    for (int t = 0; t < 40; t++) begin
      logic        we = 1'($urandom_range(0, 1));
      logic        mode = 1'($urandom_range(0, 1));
      logic [31:0] addr = ($urandom_range(0, 1) ? 32'h0001_0000 : 32'hFFFF_FF00) | 32'($urandom_range(0, 255));
      logic [31:0] wd = $urandom;
      txn(we, mode, addr, wd, we ? 32'h0 : model_load(mode, addr));
    end

    // Final memory image must match the model byte for byte
    for (int a = 0; a < 256; a++) check("final_mem", 32'(mem_arr[a]), 32'(ref_mem[a]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Initiator side of the byte-wide data memory port. Accepts one load/store request at a time from the pipeline MEM stage and serialises it into byte accesses on an 8-bit memory interface, one byte per cycle, little-endian. Words are assembled on loads and split on stores. Raises `busy` so the hazard unit stalls the pipeline until the response is delivered.

## Interface
- `ADDRESS_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, request/response data width; fixed at 4 bytes
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present from MEM stage
- `req_ready`  out  1  sequencer can accept a request this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_addr_mode`  in  1  1 = byte access, 0 = word access
- `req_addr`  in  ADDRESS_WIDTH  byte address of lowest byte
- `req_wd`  in  DATA_WIDTH  store data; the byte access uses [7:0]
- `resp_valid`  out  1  one-cycle pulse; the request has completed
- `resp_rd`  out  DATA_WIDTH  load data; valid while `resp_valid` is high
- `busy`  out  1  request in flight; the pipeline must stall
- `mem_we`  out  1  byte write enable to memory
- `mem_addr`  out  ADDRESS_WIDTH  byte address to memory
- `mem_wd`  out  8  byte write data
- `mem_rd`  in  8  byte read data; combinational from `mem_addr`

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, capture `req_we`, `req_addr_mode`, `req_addr` and `req_wd`.
  - Clear the byte counter `cnt` (2 bits) and the assembled data.
  - Go to ACCESS.
- ACCESS:
  - Drive `mem_addr` = base + `cnt`, modulo 2^ADDRESS_WIDTH, so 0xFFFFFFFE+2 wraps to 0x00000000.
  - For stores, drive `mem_we`=1 and `mem_wd` = captured byte `cnt`.
  - For loads, drive `mem_we`=0 and latch `mem_rd` into byte lane `cnt` on the clock edge.
  - The last byte is `cnt`=0 for byte mode and `cnt`=3 for word mode. On the last byte go to DONE; otherwise `cnt`+1.
- DONE:
  - `resp_valid`=1.
  - For loads, `resp_rd` = assembled data. Byte mode is zero-extended: {24'b0, byte0}.
  - For stores, `resp_rd`=0.
  - Go to IDLE unconditionally.
- `req_ready` is high only in IDLE. `req_valid` outside IDLE is ignored and not queued.
- `busy` = (state != IDLE) or (IDLE and `req_valid`), so the stall asserts in the accept cycle.
- Outside ACCESS, `mem_we`=0, `mem_addr`=0 and `mem_wd`=0.
- Memory write timing: bytes are written at the edge ending each ACCESS cycle.
- Stores write ascending addresses; no read-modify-write is performed.

## Timing
- Accept in cycle N (IDLE, `req_valid`=1).
- Byte access: ACCESS in cycle N+1, `resp_valid` in N+2.
- Word access: ACCESS in N+1..N+4, `resp_valid` in N+5.
- Back-to-back: the earliest next accept is the cycle after DONE. Throughput is one word per 6 cycles and one byte per 3 cycles.
- Reset values: state=IDLE, `cnt`=0, all captured registers 0, `resp_valid`=0, `resp_rd`=0, `mem_we`=0, `mem_addr`=0, `mem_wd`=0, `req_ready`=1, `busy`=0 (given `req_valid`=0).
- Reset mid-operation: asynchronous return to IDLE, and `mem_we` drops immediately. A partially written word stays partially written. No response is issued for the aborted request.
- `mem_rd` is sampled only in ACCESS cycles of loads.

## Structure
- Shared package `mem_access_pkg`:
  - state enum `seq_state_t` {IDLE, ACCESS, DONE}
  - constants `ADDR_MODE_BYTE`=1'b1 and `ADDR_MODE_WORD`=1'b0
  - `BYTES_PER_WORD`=4
- These mode encodings are the ones the data memory already uses, so decode logic and the memory share a single source.
- One sub-module, `byte_lane_assembler`: holds the 32-bit data register and writes byte lane `cnt` with `mem_rd` on load.
- The FSM, counter and address adder remain in the top.

## Test plan
- Word load: memory[0x10000..0x10003] = 12 34 56 78, load word at 0x10000.
  - `mem_addr` steps 0x10000→0x10003 over cycles N+1..N+4.
  - `resp_valid` pulses in N+5 with `resp_rd`=0x78563412.
- Byte load at 0x10002 (0x56): one ACCESS cycle, then `resp_rd`=0x00000056 in N+2.
- Word store of 0xDEADBEEF at 0x10010:
  - `mem_we`=1 for 4 cycles with `mem_wd` EF, BE, AD, DE.
  - A subsequent word load returns 0xDEADBEEF.
- Address wrap: word load at 0xFFFFFFFE gives `mem_addr` sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Busy/ready:
  - `req_valid` held high continuously: accepts occur only in IDLE, 6 cycles apart for words.
  - `busy` is high from the accept cycle through DONE.
  - Requests arriving during ACCESS produce no memory activity.
- Reset abort: assert `rst_n`=0 after the 2nd byte of a word store.
  - `mem_we`=0 immediately, with no `resp_valid`.
  - Only bytes 0 and 1 are modified.
  - After release, state is IDLE with `req_ready`=1.
